// File: rtl/stall_pkg.sv
// ----------------------------------------------------------------------------
// stall_pkg
// Shared definitions for the pipeline stall sequencer and the decoder that
// produces the stall code.
//   STOP_*   : 2-bit decoder stall codes (none / store / branch / load)
//   state_t  : sequencer state enumeration
//   is_wait  : true for the states that wait on an external completion event
// ----------------------------------------------------------------------------
package stall_pkg;

    localparam logic [1:0] STOP_NONE = 2'b00;
    localparam logic [1:0] STOP_ST   = 2'b01;
    localparam logic [1:0] STOP_BR   = 2'b10;
    localparam logic [1:0] STOP_LD   = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LD_WAIT = 3'd1,
        LD_USE  = 3'd2,
        ST_WAIT = 3'd3,
        BR_WAIT = 3'd4
    } state_t;

    function automatic logic is_wait(input state_t s);
        return (s == LD_WAIT) || (s == ST_WAIT) || (s == BR_WAIT);
    endfunction

endpackage

// File: rtl/wait_timer.sv
// ----------------------------------------------------------------------------
// wait_timer
// Counts cycles spent in a wait state and flags when MAX_WAIT is reached.
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset, clears the count
//   run     : high while the sequencer sits in a wait state; low clears the
//             count so every wait state is entered with count 0
//   at_max  : count equals MAX_WAIT (count saturates there, never wraps)
// MAX_WAIT must not exceed 2^CNT_W-1.
// ----------------------------------------------------------------------------
module wait_timer #(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic at_max
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] count_reg;

    assign at_max = (count_reg == MAX_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (!run) begin
            count_reg <= '0;
        end else if (!at_max) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/stall_sequencer.sv
// ----------------------------------------------------------------------------
// stall_sequencer
// Pipeline stall controller. Accepts a stall code from decode while idle,
// holds the front of the pipe until the awaited memory or branch event
// arrives (or a wait timeout fires), and inserts a load-use bubble after loads.
//   clk          : clock, rising edge
//   rst_n        : asynchronous active-low reset
//   id_valid     : decode holds a valid instruction
//   stop[1:0]    : stall code (00 none, 01 store, 10 branch, 11 load)
//   mem_ready    : data-memory completion pulse
//   br_resolved  : EX-stage branch resolution pulse
//   br_taken     : branch outcome, qualified by br_resolved
//   pc_hold      : freeze PC
//   if_id_hold   : freeze IF/ID
//   id_ex_bubble : inject NOP into ID/EX
//   if_id_flush  : clear IF/ID (taken branch resolved)
//   busy         : sequencer not idle
//   timeout      : one-cycle pulse when a wait expired without its event
// ----------------------------------------------------------------------------
module stall_sequencer
    import stall_pkg::*;
#(
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       id_valid,
    input  logic [1:0] stop,
    input  logic       mem_ready,
    input  logic       br_resolved,
    input  logic       br_taken,
    output logic       pc_hold,
    output logic       if_id_hold,
    output logic       id_ex_bubble,
    output logic       if_id_flush,
    output logic       busy,
    output logic       timeout
);

    state_t state_reg;
    state_t state_next;
    logic   at_max;

    wait_timer #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) u_wait_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .run    (is_wait(state_reg)),
        .at_max (at_max)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_hold      = 1'b0;
        if_id_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        busy         = (state_reg != IDLE);
        timeout      = 1'b0;

        case (state_reg)
            IDLE: begin
                // Hold the front end in the accept cycle itself so the
                // stalled instruction is not overwritten; the bubble starts
                // only once the wait state is entered.
                if (id_valid && (stop != STOP_NONE)) begin
                    pc_hold    = 1'b1;
                    if_id_hold = 1'b1;
                    case (stop)
                        STOP_LD: state_next = LD_WAIT;
                        STOP_ST: state_next = ST_WAIT;
                        default: state_next = BR_WAIT;
                    endcase
                end
            end
            LD_WAIT: begin
                pc_hold      = 1'b1;
                if_id_hold   = 1'b1;
                id_ex_bubble = 1'b1;
                // The event is tested first so that it wins over a timeout
                // in the cycle the counter reaches MAX_WAIT.
                if (mem_ready) begin
                    state_next = LD_USE;
                end else if (at_max) begin
                    state_next = IDLE;
                    timeout    = 1'b1;
                end
            end
            LD_USE: begin
                pc_hold      = 1'b1;
                if_id_hold   = 1'b1;
                id_ex_bubble = 1'b1;
                state_next   = IDLE;
            end
            ST_WAIT: begin
                pc_hold      = 1'b1;
                if_id_hold   = 1'b1;
                id_ex_bubble = 1'b1;
                if (mem_ready) begin
                    state_next = IDLE;
                end else if (at_max) begin
                    state_next = IDLE;
                    timeout    = 1'b1;
                end
            end
            BR_WAIT: begin
                pc_hold      = 1'b1;
                if_id_hold   = 1'b1;
                id_ex_bubble = 1'b1;
                if (br_resolved) begin
                    state_next  = IDLE;
                    if_id_flush = br_taken;
                end else if (at_max) begin
                    state_next = IDLE;
                    timeout    = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // The accept-cycle holds are combinational from the inputs, so they
        // must be masked explicitly to keep every output low during reset.
        if (!rst_n) begin
            pc_hold      = 1'b0;
            if_id_hold   = 1'b0;
            id_ex_bubble = 1'b0;
            if_id_flush  = 1'b0;
            busy         = 1'b0;
            timeout      = 1'b0;
        end
    end

endmodule

// File: tb/tb_stall_sequencer.sv
// ----------------------------------------------------------------------------
// tb_stall_sequencer
// Directed vector table, hand-written timeout/reset sequences and randomized
// traffic checked against a behavioural model of the stall rules.
// Output vector order: {pc_hold, if_id_hold, id_ex_bubble, if_id_flush,
//                       busy, timeout}
// ----------------------------------------------------------------------------
module tb_stall_sequencer;
    import stall_pkg::*;

    localparam int MAX_WAIT = 15;
    localparam int CNT_W    = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       id_valid;
    logic [1:0] stop;
    logic       mem_ready;
    logic       br_resolved;
    logic       br_taken;
    logic       pc_hold;
    logic       if_id_hold;
    logic       id_ex_bubble;
    logic       if_id_flush;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stall_sequencer #(
        .MAX_WAIT (MAX_WAIT),
        .CNT_W    (CNT_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .stop         (stop),
        .mem_ready    (mem_ready),
        .br_resolved  (br_resolved),
        .br_taken     (br_taken),
        .pc_hold      (pc_hold),
        .if_id_hold   (if_id_hold),
        .id_ex_bubble (id_ex_bubble),
        .if_id_flush  (if_id_flush),
        .busy         (busy),
        .timeout      (timeout)
    );

    // Behavioural model: the pending operation is the stop code still being
    // waited on (0 = nothing), waited = cycles already spent waiting,
    // bubble_due = the load-use bubble cycle is the current cycle.
    int m_op       = 0;
    int m_waited   = 0;
    bit m_bubble   = 1'b0;

    function automatic bit model_event();
        if (m_op == 2) return br_resolved;
        return mem_ready;
    endfunction

    function automatic logic [5:0] model_out();
        logic fl;
        logic to;
        logic acc;
        if (!rst_n) return 6'b000000;
        if (m_bubble) return 6'b111010;
        if (m_op != 0) begin
            fl = (m_op == 2) && model_event() && br_taken;
            to = !model_event() && (m_waited == MAX_WAIT);
            return {3'b111, fl, 1'b1, to};
        end
        acc = id_valid && (stop != 2'b00);
        return {acc, acc, 4'b0000};
    endfunction

    task automatic model_step();
        if (!rst_n) begin
            m_op = 0; m_waited = 0; m_bubble = 1'b0;
        end else if (m_bubble) begin
            m_bubble = 1'b0;
        end else if (m_op != 0) begin
            if (model_event()) begin
                if (m_op == 3) m_bubble = 1'b1;
                m_op = 0;
            end else if (m_waited >= MAX_WAIT) begin
                m_op = 0;
            end else begin
                m_waited = m_waited + 1;
            end
        end else if (id_valid && stop != 2'b00) begin
            m_op     = int'(stop);
            m_waited = 0;
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, compare 1 ns
    // later, then advance the model on the rising edge.
    task automatic cyc(input logic iv, input logic [1:0] sp, input logic mr,
                       input logic brr, input logic brt, input logic rn,
                       input bit use_tab, input logic [5:0] texp,
                       input string name);
        logic [5:0] exp_v;
        logic [5:0] act_v;
        @(negedge clk);
        id_valid    = iv;
        stop        = sp;
        mem_ready   = mr;
        br_resolved = brr;
        br_taken    = brt;
        rst_n       = rn;
        #1;
        exp_v = use_tab ? texp : model_out();
        act_v = {pc_hold, if_id_hold, id_ex_bubble, if_id_flush, busy, timeout};
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: outputs %b expected %b", name, act_v, exp_v);
        end else begin
            $display("ok   %s: iv=%b stop=%b mr=%b brr=%b brt=%b rst_n=%b out=%b",
                     name, iv, sp, mr, brr, brt, rn, act_v);
        end
        @(posedge clk);
        model_step();
    endtask

    typedef struct {
        logic       iv;
        logic [1:0] sp;
        logic       mr;
        logic       brr;
        logic       brt;
        logic       rn;
        logic [5:0] exp_v;
    } vec_t;

    localparam int NVEC = 19;
    vec_t tab [NVEC];

    initial begin
        rst_n = 1'b0; id_valid = 1'b0; stop = STOP_NONE;
        mem_ready = 1'b0; br_resolved = 1'b0; br_taken = 1'b0;

        // Load: mem_ready on 3rd wait cycle, then LD_USE bubble
        tab[0]  = '{1'b1, STOP_LD,   1'b0, 1'b0, 1'b0, 1'b1, 6'b110000};
        tab[1]  = '{1'b0, STOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111010};
        tab[2]  = '{1'b0, STOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111010};
        tab[3]  = '{1'b0, STOP_NONE, 1'b1, 1'b0, 1'b0, 1'b1, 6'b111010};
        tab[4]  = '{1'b0, STOP_NONE, 1'b1, 1'b0, 1'b0, 1'b1, 6'b111010};
        tab[5]  = '{1'b0, STOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};
        // Store completing on 1st wait cycle, load presented right after
        tab[6]  = '{1'b1, STOP_ST,   1'b0, 1'b0, 1'b0, 1'b1, 6'b110000};
        tab[7]  = '{1'b1, STOP_LD,   1'b1, 1'b1, 1'b0, 1'b1, 6'b111010};
        tab[8]  = '{1'b1, STOP_LD,   1'b0, 1'b0, 1'b0, 1'b1, 6'b110000};
        tab[9]  = '{1'b0, STOP_NONE, 1'b1, 1'b0, 1'b0, 1'b1, 6'b111010};
        tab[10] = '{1'b0, STOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 6'b111010};
        tab[11] = '{1'b0, STOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};
        // Branch taken on 2nd wait cycle; mem_ready ignored while waiting
        tab[12] = '{1'b1, STOP_BR,   1'b0, 1'b0, 1'b0, 1'b1, 6'b110000};
        tab[13] = '{1'b0, STOP_NONE, 1'b1, 1'b0, 1'b1, 1'b1, 6'b111010};
        tab[14] = '{1'b0, STOP_NONE, 1'b0, 1'b1, 1'b1, 1'b1, 6'b111110};
        tab[15] = '{1'b0, STOP_NONE, 1'b0, 1'b1, 1'b1, 1'b1, 6'b000000};
        // Branch not taken
        tab[16] = '{1'b1, STOP_BR,   1'b0, 1'b0, 1'b0, 1'b1, 6'b110000};
        tab[17] = '{1'b0, STOP_NONE, 1'b0, 1'b1, 1'b0, 1'b1, 6'b111010};
        tab[18] = '{1'b0, STOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 6'b000000};

        // Reset holds everything low even with an accept-looking request
        for (int i = 0; i < 3; i++)
            cyc(1'b1, STOP_LD, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'b000000, "reset");

        for (int i = 0; i < NVEC; i++)
            cyc(tab[i].iv, tab[i].sp, tab[i].mr, tab[i].brr, tab[i].brt,
                tab[i].rn, 1'b1, tab[i].exp_v, $sformatf("vec%0d", i));

        // Timeout: no mem_ready (br_resolved must not end a load wait)
        cyc(1'b1, STOP_LD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b110000, "to_accept");
        for (int i = 0; i < MAX_WAIT; i++)
            cyc(1'b0, STOP_NONE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b111010, "to_wait");
        cyc(1'b0, STOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b111011, "to_pulse");
        cyc(1'b0, STOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000, "to_idle");

        // Event in the same cycle the counter reaches MAX_WAIT wins
        cyc(1'b1, STOP_LD, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b110000, "pr_accept");
        for (int i = 0; i < MAX_WAIT; i++)
            cyc(1'b0, STOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b111010, "pr_wait");
        cyc(1'b0, STOP_NONE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 6'b111010, "pr_event");
        cyc(1'b0, STOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b111010, "pr_lduse");
        cyc(1'b0, STOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000, "pr_idle");

        // Reset mid-ST_WAIT, then a branch accepted normally
        cyc(1'b1, STOP_ST, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b110000, "rs_accept");
        cyc(1'b0, STOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b111010, "rs_wait");
        cyc(1'b1, STOP_BR, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'b000000, "rs_assert");
        cyc(1'b1, STOP_BR, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 6'b000000, "rs_held");
        cyc(1'b1, STOP_BR, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b110000, "rs_resume");
        cyc(1'b0, STOP_NONE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 6'b111110, "rs_flush");
        cyc(1'b0, STOP_NONE, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 6'b000000, "rs_idle");

        // Randomized traffic against the model
        for (int i = 0; i < 1000; i++) begin
            logic       r_iv;
            logic [1:0] r_sp;
            logic       r_mr;
            logic       r_brr;
            logic       r_brt;
            logic       r_rn;
            r_iv  = 1'($urandom_range(0, 1));
            r_sp  = 2'($urandom_range(0, 3));
            r_mr  = ($urandom_range(0, 5) == 0);
            r_brr = ($urandom_range(0, 5) == 0);
            r_brt = 1'($urandom_range(0, 1));
            r_rn  = ($urandom_range(0, 99) != 0);
            cyc(r_iv, r_sp, r_mr, r_brr, r_brt, r_rn, 1'b0, 6'b000000,
                $sformatf("rand%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
